// File: rtl/ula_mul_ctrl.sv
// ---------------------------------------------------------------------------
// ula_mul_ctrl
//   Sequences an external ULA to compute an unsigned TAM-bit product with a
//   shift-add algorithm. Each ULA command takes two cycles: an ISSUE cycle
//   where the command is presented, and a WAIT cycle where the registered
//   ULA result is consumed.
//
// Ports
//   clk       : clock, all state changes on the rising edge
//   rst       : synchronous active-high reset
//   start     : multiply request, only looked at while idle
//   op_a      : multiplicand, captured when start is accepted
//   op_b      : multiplier, captured when start is accepted
//   busy      : high whenever the controller is not idle
//   done      : one-cycle pulse when the product is ready
//   result    : product modulo 2^TAM, held until the next accepted start
//   ula_a     : ULA operand A
//   ula_b     : ULA operand B
//   ula_ctrl  : ULA command (0000 add, 0110 shift left by one, zero fill)
//   ula_out   : registered ULA result, valid one cycle after the command
// ---------------------------------------------------------------------------
module ula_mul_ctrl #(
    parameter int TAM = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [TAM-1:0] op_a,
    input  logic [TAM-1:0] op_b,
    output logic           busy,
    output logic           done,
    output logic [TAM-1:0] result,
    output logic [TAM-1:0] ula_a,
    output logic [TAM-1:0] ula_b,
    output logic [3:0]     ula_ctrl,
    input  logic [TAM-1:0] ula_out
);

    typedef enum logic [2:0] {
        IDLE,
        EVAL,
        ADD_I,
        ADD_W,
        SHL_I,
        SHL_W,
        DONE
    } state_t;

    localparam logic [3:0] CMD_ADD = 4'b0000;
    localparam logic [3:0] CMD_SHL = 4'b0110;

    state_t         r_state;
    state_t         w_nextState;

    logic [TAM-1:0] r_acc;
    logic [TAM-1:0] r_ma;
    logic [TAM-1:0] r_mb;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Datapath registers. The accumulator and shifted multiplicand only take
    // the ULA result in the WAIT half of each command, which keeps the ULA
    // operands stable across the whole ISSUE/WAIT pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_ma  <= '0;
            r_mb  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc <= '0;
                        r_ma  <= op_a;
                        r_mb  <= op_b;
                    end
                end
                ADD_W: begin
                    r_acc <= ula_out;
                end
                SHL_W: begin
                    r_ma <= ula_out;
                    r_mb <= r_mb >> 1;
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state and output decode. The loop ends as soon as the remaining
    // multiplier is zero, so high-order zero bits cost nothing.
    always_comb begin
        w_nextState = r_state;
        ula_a       = '0;
        ula_b       = '0;
        ula_ctrl    = CMD_ADD;
        busy        = 1'b1;
        done        = 1'b0;

        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_nextState = EVAL;
                end
            end
            EVAL: begin
                if (r_mb == '0) begin
                    w_nextState = DONE;
                end else if (r_mb[0]) begin
                    w_nextState = ADD_I;
                end else begin
                    w_nextState = SHL_I;
                end
            end
            ADD_I, ADD_W: begin
                ula_a    = r_acc;
                ula_b    = r_ma;
                ula_ctrl = CMD_ADD;
                w_nextState = (r_state == ADD_I) ? ADD_W : SHL_I;
            end
            SHL_I, SHL_W: begin
                ula_a    = r_ma;
                ula_b    = '0;
                ula_ctrl = CMD_SHL;
                w_nextState = (r_state == SHL_I) ? SHL_W : EVAL;
            end
            DONE: begin
                done        = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    assign result = r_acc;

endmodule

// File: tb/tb_ula_mul_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ula_mul_ctrl
//   Scoreboard bench for ula_mul_ctrl. Stimulus pushes the expected product
//   and the expected done cycle; a monitor pops and compares on every done.
//   A small behavioural ULA with a one-cycle registered output is included.
// ---------------------------------------------------------------------------
module tb_ula_mul_ctrl;

    localparam int TAM = 16;

    typedef struct {
        logic [TAM-1:0] expResult;
        int             expCycle;
        string          name;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [TAM-1:0] op_a = '0;
    logic [TAM-1:0] op_b = '0;
    logic           busy;
    logic           done;
    logic [TAM-1:0] result;
    logic [TAM-1:0] ula_a;
    logic [TAM-1:0] ula_b;
    logic [3:0]     ula_ctrl;
    logic [TAM-1:0] ula_out = '0;

    int   cycleCnt = 0;
    int   addCnt = 0;
    int   nChecks = 0;
    int   nPass = 0;
    exp_t expQ[$];

    ula_mul_ctrl #(.TAM(TAM)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op_a     (op_a),
        .op_b     (op_b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .ula_a    (ula_a),
        .ula_b    (ula_b),
        .ula_ctrl (ula_ctrl),
        .ula_out  (ula_out)
    );

    always #5 clk = ~clk;

    // Free-running cycle counter used to time done against the model.
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Behavioural ULA: registered result, add or shift-left-by-one.
    always @(posedge clk) begin
        case (ula_ctrl)
            4'b0000: ula_out <= ula_a + ula_b;
            4'b0110: ula_out <= ula_a << 1;
            default: ula_out <= '0;
        endcase
    end

    // Counts cycles in which an add with a nonzero addend is on the ULA bus.
    always @(negedge clk) begin
        if (ula_ctrl == 4'b0000 && ula_b != '0) addCnt <= addCnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
    endtask

    // Expected latency from the start-sampling edge to done.
    function automatic int latency(input logic [TAM-1:0] b);
        int lat = 2;
        for (int i = 0; i < TAM; i++) begin
            if ((b >> i) != '0) lat += 3 + 2 * int'(b[i]);
        end
        return lat;
    endfunction

    // Monitor: every done must match the head of the scoreboard.
    always @(negedge clk) begin
        if (done) begin
            if (expQ.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                check({e.name, "_result"}, 32'(result), 32'(e.expResult));
                check({e.name, "_done_cycle"}, cycleCnt, e.expCycle);
            end
        end
    end

    task automatic waitDrain(input string name);
        for (int i = 0; i < 300 && expQ.size() != 0; i++) @(negedge clk);
        if (expQ.size() != 0) begin
            check({name, "_timeout"}, 32'd1, 32'd0);
            expQ.delete();
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    // Issue one multiply (called at a negedge) and scramble the operands
    // afterwards so late operand changes would show up in the product.
    task automatic applyStimulus(input string name, input logic [TAM-1:0] a,
                                 input logic [TAM-1:0] b, input logic [TAM-1:0] expRes);
        exp_t e;
        e.expResult = expRes;
        e.expCycle  = cycleCnt + latency(b);
        e.name      = name;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        expQ.push_back(e);
        @(negedge clk);
        start = 1'b0;
        op_a  = TAM'($urandom);
        op_b  = TAM'($urandom);
    endtask

    initial begin
        int c;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_ula_a", 32'(ula_a), 32'd0);
        check("rst_ula_ctrl", 32'(ula_ctrl), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 3 x 5 with an ignored start mid-run and another during DONE.
        addCnt = 0;
        c = cycleCnt;
        applyStimulus("mul_3x5", 16'd3, 16'd5, 16'h000F);
        while (cycleCnt < c + 16) begin
            if (cycleCnt == c + 5) begin
                op_a = 16'd7; op_b = 16'd7; start = 1'b1;
            end else if (cycleCnt == c + 15) begin
                op_a = 16'd7; op_b = 16'd7; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (cycleCnt >= c + 1 && cycleCnt <= c + 15 && (cycleCnt - c) % 5 == 0)
                check("mul_3x5_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        start = 1'b0;
        check("mul_3x5_busy_after", 32'(busy), 32'd0);
        check("mul_3x5_add_cycles", addCnt, 32'd4);
        @(negedge clk);
        check("mul_3x5_held", 32'(result), 32'h000F);
        check("ignored_start_busy", 32'(busy), 32'd0);
        waitDrain("mul_3x5");

        // Zero multiplier: no add may reach the ULA.
        addCnt = 0;
        applyStimulus("mul_1234x0", 16'h1234, 16'h0000, 16'h0000);
        waitDrain("mul_1234x0");
        check("mul_1234x0_no_add", addCnt, 32'd0);

        applyStimulus("mul_ffffxffff", 16'hFFFF, 16'hFFFF, 16'h0001);
        waitDrain("mul_ffffxffff");
        applyStimulus("mul_0100x0100", 16'h0100, 16'h0100, 16'h0000);
        waitDrain("mul_0100x0100");
        applyStimulus("mul_00ffx0101", 16'h00FF, 16'h0101, 16'hFFFF);
        waitDrain("mul_00ffx0101");
        applyStimulus("mul_13x11", 16'd13, 16'd11, 16'h008F);
        waitDrain("mul_13x11");
        applyStimulus("mul_8000x2", 16'h8000, 16'h0002, 16'h0000);
        waitDrain("mul_8000x2");

        // Reset aborts a 3 x 5 run; no done may follow (monitor flags it).
        c = cycleCnt;
        op_a = 16'd3; op_b = 16'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cycleCnt < c + 6) @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_ula_b", 32'(ula_b), 32'd0);
        repeat (20) @(negedge clk);
        check("abort_stays_idle", 32'(busy), 32'd0);

        applyStimulus("mul_2x2", 16'd2, 16'd2, 16'h0004);
        waitDrain("mul_2x2");

        $display("[TB] %0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/ula_mul_ctrl.md
ULA_MUL_CTRL -- requirements
Module: ula_mul_ctrl

Interface
REQ-001 SHALL have parameter TAM, default 16, giving the operand, result and ULA datapath width in bits.
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1: multiply request, sampled only in IDLE.
REQ-005 SHALL have port op_a, input, TAM: multiplicand, captured on start acceptance.
REQ-006 SHALL have port op_b, input, TAM: multiplier, captured on start acceptance.
REQ-007 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-008 SHALL have port done, output, 1: one-cycle pulse, high only in the DONE state.
REQ-009 SHALL have port result, output, TAM: product modulo 2^TAM, valid from DONE until the next accepted start.
REQ-010 SHALL have port ula_a, output, TAM: ULA operand A.
REQ-011 SHALL have port ula_b, output, TAM: ULA operand B.
REQ-012 SHALL have port ula_ctrl, output, 4: ULA command.
REQ-013 SHALL have port ula_out, input, TAM: registered ULA result, valid one cycle after a command is issued.

Function
REQ-014 SHALL use an unsigned shift-add algorithm with registers acc (accumulator), ma (shifted multiplicand) and mb (remaining multiplier), all TAM bits wide.
REQ-015 SHALL, when start=1 in IDLE, load acc=0, ma=op_a and mb=op_b, then enter EVAL on the next edge.
REQ-016 SHALL implement states IDLE, EVAL, ADD_I, ADD_W, SHL_I, SHL_W and DONE.
REQ-017 SHALL make these transitions from EVAL: mb==0 -> DONE; mb[0]=1 -> ADD_I; otherwise -> SHL_I.
REQ-018 SHALL in ADD_I and ADD_W drive ula_a=acc, ula_b=ma and ula_ctrl=4'b0000 (add), load acc<=ula_out at the end of ADD_W, and go ADD_I->ADD_W->SHL_I.
REQ-019 SHALL in SHL_I and SHL_W drive ula_a=ma, ula_b=0 and ula_ctrl=4'b0110 (shift left, zero fill), load ma<=ula_out and mb<=mb>>1 at the end of SHL_W, and go SHL_I->SHL_W->EVAL.
REQ-020 SHALL hold ula_a, ula_b and ula_ctrl stable across each ISSUE/WAIT pair; it SHALL NOT use ULA flags.
REQ-021 SHALL drive ula_a=0, ula_b=0 and ula_ctrl=4'b0000 in IDLE, EVAL and DONE.
REQ-022 SHALL drive result from acc, and SHALL go from DONE to IDLE unconditionally after one cycle.
REQ-023 SHALL give a latency, counted from the start-sampling edge to the first cycle with done high, of 2 + sum over bit positions i=0..msb(op_b) of (3 + 2*op_b[i]); with op_b=0 the latency SHALL be 2.
REQ-024 SHALL ignore start whenever busy=1, including in DONE; operands captured at acceptance SHALL be unaffected by later changes to op_a and op_b.
REQ-025 SHALL wrap overflow silently, so result = (op_a*op_b) mod 2^TAM.

Reset
REQ-026 SHALL, with rst=1 at a clock edge, force state=IDLE, busy=0, done=0, result=0, acc=ma=mb=0, and ULA outputs to 0, regardless of state.
REQ-027 SHALL give rst priority over start in the same cycle; an operation aborted by reset SHALL NOT produce done.

Verification
REQ-028 SHALL verify: op_a=3, op_b=5, start pulse -> done in cycle 15, result=0x000F, busy high in cycles 1-15.
REQ-029 SHALL verify: op_a=0x1234, op_b=0 -> done in cycle 2, result=0x0000, no ULA add issued.
REQ-030 SHALL verify: op_a=0xFFFF, op_b=0xFFFF -> done in cycle 82, result=0x0001 (wrap).
REQ-031 SHALL verify: op_a=0x0100, op_b=0x0100 -> done in cycle 31, result=0x0000.
REQ-032 SHALL verify: new start with op_a=7, op_b=7 at cycle 5 of the 3x5 run -> ignored, result=0x000F; a start pulse during DONE -> ignored.
REQ-033 SHALL verify: rst=1 at cycle 6 of the 3x5 run -> the next cycle shows busy=0, done=0, result=0; a subsequent 2x2 run gives result=0x0004.
